// File: rtl/sumcheck_round_verifier.sv
// Sum-check protocol verifier: checks each round polynomial against the running claim and
// folds in a random challenge. Optional macro SUMCHECK_EARLY_ABORT_EN ends the protocol on the first failed check.
module sumcheck_round_verifier #(
    parameter int                    UINT_WIDTH = 32,
    parameter int                    NUM_VARS   = 6,
    parameter logic [UINT_WIDTH-1:0] MODULUS    = 32'hFFFFFFFB
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic                            start,
    input  logic [UINT_WIDTH-1:0]           claim,
    input  logic                            pt_valid,
    output logic                            pt_ready,
    input  logic [UINT_WIDTH-1:0]           pt0,
    input  logic [UINT_WIDTH-1:0]           pt1,
    input  logic [UINT_WIDTH-1:0]           pt2,
    input  logic                            rand_valid,
    input  logic [UINT_WIDTH-1:0]           rand_in,
    output logic                            chal_valid,
    output logic [UINT_WIDTH-1:0]           chal_out,
    output logic [$clog2(NUM_VARS+1)-1:0]   round,
    input  logic                            final_valid,
    input  logic [UINT_WIDTH-1:0]           final_val,
    output logic                            busy,
    output logic                            done,
    output logic                            accept,
    output logic [2:0]                      dbg_state
);

    localparam int W  = UINT_WIDTH;
    localparam int RW = $clog2(NUM_VARS+1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_PTS   = 3'd1;
    localparam logic [2:0] S_CHECK      = 3'd2;
    localparam logic [2:0] S_WAIT_RAND  = 3'd3;
    localparam logic [2:0] S_EVAL1      = 3'd4;
    localparam logic [2:0] S_EVAL2      = 3'd5;
    localparam logic [2:0] S_WAIT_FINAL = 3'd6;
    localparam logic [2:0] S_FINISH     = 3'd7;

    localparam logic [W:0]    M_EXT      = {1'b0, MODULUS};
    localparam logic [W:0]    INV2_EXT   = (M_EXT + 1'b1) >> 1;
    localparam logic [W-1:0]  INV2       = INV2_EXT[W-1:0];
    localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_VARS - 1);

    function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= M_EXT) s = s - M_EXT;
        return W'(s);
    endfunction

    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        if (a >= b) s = {1'b0, a} - {1'b0, b};
        else        s = {1'b0, a} + M_EXT - {1'b0, b};
        return W'(s);
    endfunction

    function automatic logic [W-1:0] mul_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] prod;
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return W'(prod % {{W{1'b0}}, MODULUS});
    endfunction

    logic [2:0]    r_state;
    logic [W-1:0]  r_e;
    logic [RW-1:0] r_round;
    logic          r_fail;
    logic          r_done;
    logic [W-1:0]  r_pt0, r_pt1, r_pt2;
    logic [W-1:0]  r_chal;
    logic [W-1:0]  r_ca, r_cb, r_cc;

    logic [W-1:0]  w_sum;
    logic [W-1:0]  w_rand_red;
    logic [W-1:0]  w_rm1, w_rm2;
    logic [W-1:0]  w_ca, w_cb, w_cc;
    logic [W-1:0]  w_e_next;
    logic          w_mismatch;

    assign w_sum      = add_mod(r_pt0, r_pt1);
    assign w_mismatch = (w_sum != r_e);
    assign w_rand_red = (rand_in >= MODULUS) ? (rand_in - MODULUS) : rand_in;

    // Lagrange basis weights at r for nodes 0,1,2; the pt1 weight is kept positive and subtracted later.
    assign w_rm1 = sub_mod(r_chal, W'(1));
    assign w_rm2 = sub_mod(r_chal, W'(2));
    assign w_ca  = mul_mod(mul_mod(w_rm1, w_rm2), INV2);
    assign w_cb  = mul_mod(r_chal, w_rm2);
    assign w_cc  = mul_mod(mul_mod(r_chal, w_rm1), INV2);

    assign w_e_next = sub_mod(add_mod(mul_mod(r_pt0, r_ca), mul_mod(r_pt2, r_cc)),
                              mul_mod(r_pt1, r_cb));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_e     <= '0;
            r_round <= '0;
            r_fail  <= 1'b0;
            r_done  <= 1'b0;
            r_pt0   <= '0;
            r_pt1   <= '0;
            r_pt2   <= '0;
            r_chal  <= '0;
            r_ca    <= '0;
            r_cb    <= '0;
            r_cc    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_FINISH: begin
                    if (start) begin
                        r_e     <= claim;
                        r_round <= '0;
                        r_fail  <= 1'b0;
                        r_done  <= 1'b0;
                        r_state <= S_WAIT_PTS;
                    end
                end
                S_WAIT_PTS: begin
                    if (pt_valid) begin
                        r_pt0   <= pt0;
                        r_pt1   <= pt1;
                        r_pt2   <= pt2;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_mismatch) r_fail <= 1'b1;
`ifdef SUMCHECK_EARLY_ABORT_EN
                    if (w_mismatch) begin
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_state <= S_WAIT_RAND;
                    end
`else
                    // Failure is only recorded so every proof takes the same number of cycles.
                    r_state <= S_WAIT_RAND;
`endif
                end
                S_WAIT_RAND: begin
                    if (rand_valid) begin
                        r_chal  <= w_rand_red;
                        r_state <= S_EVAL1;
                    end
                end
                S_EVAL1: begin
                    r_ca    <= w_ca;
                    r_cb    <= w_cb;
                    r_cc    <= w_cc;
                    r_state <= S_EVAL2;
                end
                S_EVAL2: begin
                    r_e     <= w_e_next;
                    r_round <= r_round + 1'b1;
                    r_state <= (r_round == LAST_ROUND) ? S_WAIT_FINAL : S_WAIT_PTS;
                end
                S_WAIT_FINAL: begin
                    if (final_valid) begin
                        if (final_val != r_e) r_fail <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pt_ready   = (r_state == S_WAIT_PTS);
    assign chal_valid = (r_state == S_EVAL2);
    assign chal_out   = chal_valid ? r_chal : '0;
    assign round      = r_round;
    assign busy       = (r_state != S_IDLE) && (r_state != S_FINISH);
    assign done       = r_done;
    assign accept     = r_done & ~r_fail;
    assign dbg_state  = r_state;

endmodule
